jbuf_rr_arbiter: RTL

JBUF_RR_ARBITER -- requirements
Module: jbuf_rr_arbiter

---
 rtl/jbuf_rr_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/jbuf_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jbuf_rr_arbiter
// Purpose  : Round-robin arbiter with a one-word output buffer. In IDLE it
//            picks one active requester, starting the search just above the
//            last granted index and wrapping around. It pulses that
//            requester's grant bit for one cycle and captures its data word.
//            The word is held in HOLD until the consumer accepts it, after
//            which the arbiter returns to IDLE and samples req again.
// Ports    : clk        - single clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req        - per-requester request, bit i = requester i
//            din        - packed data, requester i at [i*DW +: DW]
//            gnt        - registered one-hot grant pulse
//            dout       - buffered data of the granted requester
//            dout_valid - dout holds an unconsumed word
//            dout_ready - consumer accepts dout when high with dout_valid
//            busy       - high while the buffer is occupied (HOLD)
// Revision : 1.0 - initial release
// ============================================================================
module jbuf_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               busy
);

    localparam int LW = $clog2(NREQ);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         r_state;
    logic [LW-1:0]  r_last;

    logic [DW-1:0]  w_din_arr [NREQ];
    logic [NREQ-1:0] w_upper_mask;
    logic [NREQ-1:0] w_req_upper;
    logic [LW-1:0]  w_sel;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_din_arr[i] = din[i*DW +: DW];
    end

    // Lowest set bit of a vector; returns 0 when the vector is empty.
    function automatic logic [LW-1:0] lowest_set(input logic [NREQ-1:0] v);
        logic [LW-1:0] s;
        s = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) s = LW'(i);
        end
        return s;
    endfunction

    // Round-robin search is split into two passes: requesters strictly
    // above the last grant win first; if none of those are active the
    // search wraps and the lowest active requester wins. The last-granted
    // requester therefore always has the lowest priority.
    always_comb begin
        w_upper_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_upper_mask[i] = (LW'(i) > r_last);
        end
        w_req_upper = req & w_upper_mask;
        if (w_req_upper != '0) begin
            w_sel = lowest_set(w_req_upper);
        end else begin
            w_sel = lowest_set(req);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= LW'(NREQ - 1);
            gnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (req != '0) begin
                        gnt        <= NREQ'(1) << w_sel;
                        dout       <= w_din_arr[w_sel];
                        dout_valid <= 1'b1;
                        r_last     <= w_sel;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    // req and din are ignored here so dout stays stable
                    // until the consumer takes it.
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == HOLD);

endmodule
`default_nettype wire
